// File: rtl/hazard_stall_ctrl.sv
// Stall and mult/div sequencing control for the five-stage MIPS pipeline.
// Decodes D/E/M instruction words into Tuse/Tnew and owns the HI/LO busy counter.
module hazard_stall_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] IMcode_D,
   input  logic [31:0] IMcode_E,
   input  logic [31:0] IMcode_M,
   output logic        Stall,
   output logic        md_start,
   output logic        md_busy,
   output logic [3:0]  md_cnt
);

   localparam int unsigned CNT_W = 4;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] F_JR    = 6'h08;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   // Tuse of 3 means "not read": it is never below any Tnew (max 2).
   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   // D-stage decode: {uses HI/LO unit, Tuse rs, Tuse rt}
   function automatic logic [4:0] src_tuse(input logic [31:0] ins);
      logic       md;
      logic [1:0] tu_rs;
      logic [1:0] tu_rt;
      md    = 1'b0;
      tu_rs = TUSE_NONE;
      tu_rt = TUSE_NONE;
      case (ins[31:26])
         OP_SPECIAL: begin
            case (ins[5:0])
               F_JR: tu_rs = 2'd0;
               F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                  md    = 1'b1;
                  tu_rs = 2'd1;
                  tu_rt = 2'd1;
               end
               F_MTHI, F_MTLO: begin
                  md    = 1'b1;
                  tu_rs = 2'd1;
               end
               F_MFHI, F_MFLO: md = 1'b1;
               default: begin
                  tu_rs = 2'd1;
                  tu_rt = 2'd1;
               end
            endcase
         end
         OP_BEQ, OP_BNE: begin
            tu_rs = 2'd0;
            tu_rt = 2'd0;
         end
         OP_ADDIU, OP_ORI, OP_SLTI, OP_LW: tu_rs = 2'd1;
         OP_SW: begin
            tu_rs = 2'd1;
            tu_rt = 2'd2;
         end
         default: ;
      endcase
      return {md, tu_rs, tu_rt};
   endfunction

   // Destination register and Tnew as seen from the E stage; dst 0 means none.
   function automatic logic [6:0] dst_tnew(input logic [31:0] ins);
      logic [4:0] dst;
      logic [1:0] tnew;
      dst  = 5'd0;
      tnew = 2'd0;
      if (ins != 32'd0) begin
         case (ins[31:26])
            OP_SPECIAL: begin
               case (ins[5:0])
                  F_JR, F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: ;
                  default: begin
                     dst  = ins[15:11];
                     tnew = 2'd1;
                  end
               endcase
            end
            OP_ADDIU, OP_ORI, OP_SLTI, OP_LUI: begin
               dst  = ins[20:16];
               tnew = 2'd1;
            end
            OP_LW: begin
               dst  = ins[20:16];
               tnew = 2'd2;
            end
            OP_JAL: dst = 5'd31;
            default: ;
         endcase
      end
      return {dst, tnew};
   endfunction

   logic             d_md;
   logic [1:0]       tuse_rs;
   logic [1:0]       tuse_rt;
   logic [4:0]       rs_d;
   logic [4:0]       rt_d;
   logic [4:0]       dst_e;
   logic [1:0]       tnew_e;
   logic [4:0]       dst_m;
   logic [1:0]       tnew_m_e;
   logic [1:0]       tnew_m;
   logic             e_mult;
   logic             e_div;
   logic             stall_rs;
   logic             stall_rt;
   logic             stall_md;
   logic [CNT_W-1:0] cnt_nxt;

   // Hazard detection and mult/div start
   always_comb begin
      {d_md, tuse_rs, tuse_rt} = src_tuse(IMcode_D);
      {dst_e, tnew_e}          = dst_tnew(IMcode_E);
      {dst_m, tnew_m_e}        = dst_tnew(IMcode_M);
      rs_d     = IMcode_D[25:21];
      rt_d     = IMcode_D[20:16];
      // One stage later every Tnew has dropped by one; only lw still pending.
      tnew_m   = (tnew_m_e == 2'd2) ? 2'd1 : 2'd0;
      e_mult   = (IMcode_E[31:26] == OP_SPECIAL) &&
                 ((IMcode_E[5:0] == F_MULT) || (IMcode_E[5:0] == F_MULTU));
      e_div    = (IMcode_E[31:26] == OP_SPECIAL) &&
                 ((IMcode_E[5:0] == F_DIV) || (IMcode_E[5:0] == F_DIVU));
      md_start = (e_mult || e_div) && (md_cnt == '0);
      stall_rs = (rs_d != 5'd0) &&
                 (((rs_d == dst_e) && (tuse_rs < tnew_e)) ||
                  ((rs_d == dst_m) && (tuse_rs < tnew_m)));
      stall_rt = (rt_d != 5'd0) &&
                 (((rt_d == dst_e) && (tuse_rt < tnew_e)) ||
                  ((rt_d == dst_m) && (tuse_rt < tnew_m)));
      stall_md = d_md && (md_busy || md_start);
      Stall    = stall_rs || stall_rt || stall_md;
   end

   // Busy counter next value
   always_comb begin
      cnt_nxt = md_cnt;
      if (md_start) begin
         cnt_nxt = e_div ? DIV_LOAD : MULT_LOAD;
      end else if (md_cnt != '0) begin
         cnt_nxt = md_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         md_cnt  <= '0;
         md_busy <= 1'b0;
      end else begin
         md_cnt  <= cnt_nxt;
         md_busy <= (cnt_nxt != '0);
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a pipeline model feeds D/E/M, a
// reference model predicts each cycle's outputs, a negedge monitor compares.
module tb_hazard_stall_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;
   localparam int NONE   = 99;

   logic        CLK;
   logic        Reset;
   logic [31:0] IMcode_D;
   logic [31:0] IMcode_E;
   logic [31:0] IMcode_M;
   logic        Stall;
   logic        md_start;
   logic        md_busy;
   logic [3:0]  md_cnt;

   hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .IMcode_D (IMcode_D),
      .IMcode_E (IMcode_E),
      .IMcode_M (IMcode_M),
      .Stall    (Stall),
      .md_start (md_start),
      .md_busy  (md_busy),
      .md_cnt   (md_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int md_end = 0;
   int stall_seen = 0;
   int busy_seen = 0;
   logic [31:0] pd = 32'd0;
   logic [31:0] pe = 32'd0;
   logic [31:0] pm = 32'd0;
   logic [31:0] prog_q[$];
   logic [6:0]  exp_q[$];
   logic [6:0]  got_v;
   logic [6:0]  exp_v;

   function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] f);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   // Reference model: plain per-instruction facts, Tnew shrinks by one each stage.
   function automatic int md_len(input logic [31:0] ins);
      logic [5:0] op;
      logic [5:0] f;
      op = ins[31:26];
      f  = ins[5:0];
      if (op != 6'h00) return 0;
      if (f == 6'h18 || f == 6'h19) return MULT_N;
      if (f == 6'h1A || f == 6'h1B) return DIV_N;
      return 0;
   endfunction

   function automatic bit md_user(input logic [31:0] ins);
      logic [5:0] f;
      f = ins[5:0];
      return (ins[31:26] == 6'h00) &&
             ((f >= 6'h10 && f <= 6'h13) || (f >= 6'h18 && f <= 6'h1B));
   endfunction

   // Cycles until a source operand is consumed (which: 0 = rs, 1 = rt).
   function automatic int need(input logic [31:0] ins, input int which);
      logic [5:0] op;
      logic [5:0] f;
      op = ins[31:26];
      f  = ins[5:0];
      case (op)
         6'h00: begin
            if (f == 6'h08) return (which == 0) ? 0 : NONE;
            if (f == 6'h10 || f == 6'h12) return NONE;
            if (f == 6'h11 || f == 6'h13) return (which == 0) ? 1 : NONE;
            return 1;
         end
         6'h04, 6'h05: return 0;
         6'h09, 6'h0D, 6'h0A, 6'h23: return (which == 0) ? 1 : NONE;
         6'h2B: return (which == 0) ? 1 : 2;
         default: return NONE;
      endcase
   endfunction

   function automatic int dest(input logic [31:0] ins);
      logic [5:0] op;
      logic [5:0] f;
      op = ins[31:26];
      f  = ins[5:0];
      if (ins == 32'd0) return 0;
      case (op)
         6'h00: begin
            if (f == 6'h08 || f == 6'h11 || f == 6'h13 || (f >= 6'h18 && f <= 6'h1B)) return 0;
            return int'(ins[15:11]);
         end
         6'h09, 6'h0D, 6'h0A, 6'h0F, 6'h23: return int'(ins[20:16]);
         6'h03: return 31;
         default: return 0;
      endcase
   endfunction

   function automatic int ready_in_e(input logic [31:0] ins);
      if (ins[31:26] == 6'h23) return 2;
      if (ins[31:26] == 6'h03) return 0;
      return 1;
   endfunction

   function automatic bit data_stall(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
      int s;
      int u;
      for (int w = 0; w < 2; w++) begin
         s = (w == 0) ? int'(d[25:21]) : int'(d[20:16]);
         u = need(d, w);
         if (s != 0 && u != NONE) begin
            if (dest(e) == s && u < ready_in_e(e)) return 1'b1;
            if (dest(m) == s && u < ready_in_e(m) - 1) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic int cnt_now();
      return (md_end >= cyc) ? (md_end - cyc + 1) : 0;
   endfunction

   function automatic int rreg();
      int r;
      r = int'($urandom_range(0, 8));
      return (r == 8) ? 31 : r;
   endfunction

   function automatic logic [31:0] rand_ins();
      int k;
      int a;
      int b;
      int c;
      int imm;
      k   = int'($urandom_range(0, 19));
      a   = rreg();
      b   = rreg();
      c   = rreg();
      imm = int'($urandom_range(0, 65535));
      case (k)
         0:       return r_ins(a, b, c, 6'h21);
         1:       return r_ins(a, b, c, 6'h23);
         2:       return r_ins(a, b, c, 6'h25);
         3:       return r_ins(a, b, c, 6'h2A);
         4:       return i_ins(6'h09, a, b, imm);
         5:       return i_ins(6'h0D, a, b, imm);
         6:       return i_ins(6'h0A, a, b, imm);
         7:       return i_ins(6'h0F, 0, b, imm);
         8, 9:    return i_ins(6'h23, a, b, imm);
         10:      return i_ins(6'h2B, a, b, imm);
         11:      return i_ins(6'h04, a, b, imm);
         12:      return i_ins(6'h05, a, b, imm);
         13:      return r_ins(a, 0, 0, 6'h08);
         14:      return {6'h03, 26'($urandom)};
         15:      return {6'h02, 26'($urandom)};
         16:      return r_ins(a, b, 0, ($urandom_range(0, 1) == 0) ? 6'h18 : 6'h19);
         17:      return r_ins(a, b, 0, ($urandom_range(0, 1) == 0) ? 6'h1A : 6'h1B);
         18:      return r_ins(0, 0, c, ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12);
         default: return r_ins(a, 0, 0, ($urandom_range(0, 1) == 0) ? 6'h11 : 6'h13);
      endcase
   endfunction

   // One pipeline cycle: drive, predict, advance the pipeline model.
   task automatic step(input bit rst, input bit chk);
      int cnt;
      bit start;
      bit stall;
      Reset    = rst;
      IMcode_D = pd;
      IMcode_E = pe;
      IMcode_M = pm;
      cnt   = cnt_now();
      start = (md_len(pe) != 0) && (cnt == 0);
      stall = data_stall(pd, pe, pm) || (md_user(pd) && (cnt != 0 || start));
      if (chk) exp_q.push_back({stall, start, (cnt != 0), 4'(cnt)});
      if (rst) md_end = cyc;
      else if (start) md_end = cyc + md_len(pe);
      pm = pe;
      if (stall) begin
         pe = 32'd0;
      end else begin
         pe = pd;
         pd = (prog_q.size() != 0) ? prog_q.pop_front() : 32'd0;
      end
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic check_cnt(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic run_seg(input string name, input int ncyc, input int want_stall, input int want_busy);
      int s0;
      int b0;
      s0 = stall_seen;
      b0 = busy_seen;
      repeat (ncyc) step(1'b0, 1'b1);
      check_cnt({name, "_stall_cycles"}, stall_seen - s0, want_stall);
      check_cnt({name, "_busy_cycles"}, busy_seen - b0, want_busy);
   endtask

   // Monitor: one comparison per cycle against the scoreboard
   always @(negedge CLK) begin
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         got_v = {Stall, md_start, md_busy, md_cnt};
         checks++;
         if (Stall) stall_seen++;
         if (md_busy) busy_seen++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_out cyc=%0d got stall=%b start=%b busy=%b cnt=%0d want stall=%b start=%b busy=%b cnt=%0d",
                     cyc, got_v[6], got_v[5], got_v[4], got_v[3:0],
                     exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish, want finish before 500000");
      $fatal(1, "timeout");
   end

   initial begin
      int s0;
      bit done;
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);

      prog_q.push_back(i_ins(6'h23, 0, 8, 0));
      prog_q.push_back(r_ins(8, 8, 9, 6'h21));
      run_seg("load_use", 8, 1, 0);

      prog_q.push_back(r_ins(1, 2, 3, 6'h21));
      prog_q.push_back(i_ins(6'h04, 3, 0, 4));
      run_seg("branch_alu", 8, 1, 0);

      prog_q.push_back(r_ins(1, 2, 0, 6'h21));
      prog_q.push_back(i_ins(6'h04, 0, 0, 4));
      run_seg("branch_zero", 8, 0, 0);

      prog_q.push_back(i_ins(6'h23, 0, 5, 0));
      prog_q.push_back(i_ins(6'h2B, 6, 5, 0));
      run_seg("sw_data", 8, 0, 0);

      prog_q.push_back(i_ins(6'h23, 0, 6, 0));
      prog_q.push_back(i_ins(6'h2B, 6, 5, 0));
      run_seg("sw_base", 8, 1, 0);

      prog_q.push_back(r_ins(1, 2, 0, 6'h18));
      prog_q.push_back(r_ins(0, 0, 4, 6'h12));
      run_seg("mult_mflo", 14, 6, MULT_N);

      prog_q.push_back(r_ins(1, 2, 0, 6'h1A));
      prog_q.push_back(r_ins(1, 2, 7, 6'h21));
      run_seg("div_addu", 16, 0, DIV_N);

      prog_q.push_back(r_ins(1, 2, 0, 6'h1A));
      prog_q.push_back(r_ins(3, 4, 0, 6'h1A));
      run_seg("div_div", 30, 11, 2 * DIV_N);

      // Reset while the divider count reads 7; the waiting mfhi then proceeds
      prog_q.push_back(r_ins(1, 2, 0, 6'h1A));
      prog_q.push_back(r_ins(0, 0, 3, 6'h10));
      s0   = stall_seen;
      done = 1'b0;
      repeat (16) begin
         if (!done && cnt_now() == 7) begin
            done = 1'b1;
            step(1'b1, 1'b1);
         end else begin
            step(1'b0, 1'b1);
         end
      end
      check_cnt("reset_mid_div_stall_cycles", stall_seen - s0, 5);

      repeat (3000) begin
         while (prog_q.size() < 4) prog_q.push_back(rand_ins());
         step(($urandom_range(0, 99) == 0), 1'b1);
      end
      prog_q.delete();
      repeat (4) step(1'b0, 1'b1);

      check_cnt("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Stall and multiply/divide sequencing controller for the five-stage MIPS pipeline. It decodes the instruction words held in D, E and M. It raises `Stall` when the D-stage instruction needs a register value that no forwarding path can supply in time, or when it needs the busy HI/LO unit. `Stall` drives the PC/F_D hold enables and the D_E register's stall input, which loads a bubble (IMcode 0, PC 32'h3000). The block also owns the multi-cycle mult/div busy counter and issues the start pulse to the HI/LO unit.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu.
- `DIV_CYCLES`, 10: busy cycles for div/divu.
- `CLK`  in  1  clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `IMcode_D`  in  32  instruction in D stage.
- `IMcode_E`  in  32  instruction in E stage.
- `IMcode_M`  in  32  instruction in M stage.
- `Stall`  out  1  hold PC and F_D; bubble into D_E.
- `md_start`  out  1  one-cycle start pulse to the HI/LO unit.
- `md_busy`  out  1  HI/LO unit busy (registered).
- `md_cnt`  out  4  remaining busy cycles (registered, debug).

## Operation
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- Tuse for the D-stage instruction:
  - beq(04)/bne(05): rs and rt use 0.
  - jr (op 0, funct 08): rs use 0.
  - R-type ALU ops (op 0, other functs): rs and rt use 1.
  - addiu(09), ori(0D), slti(0A), lw(23): rs use 1.
  - sw(2B): rs use 1, rt use 2.
  - mult/multu/div/divu (op 0, funct 18/19/1A/1B): rs and rt use 1.
  - mthi/mtlo (funct 11/13): rs use 1.
  - lui(0F), j(02), jal(03), mfhi/mflo (funct 10/12): no source.
- Destination and Tnew in E:
  - R-type ALU ops and mfhi/mflo: rd, Tnew 1.
  - addiu/ori/slti/lui: rt, Tnew 1.
  - lw: rt, Tnew 2.
  - jal: $31, Tnew 0.
  - All others, including IMcode 0: no destination.
- Tnew in M: lw Tnew 1; all other writers Tnew 0.
- Data stall, per source register of D: raise when that source is non-zero, equals the dest of E or M, and its Tuse < that stage's Tnew. $0 never stalls.
- MD start: `md_start` = 1 when E holds mult/multu/div/divu and `md_cnt`=0. Combinational, one cycle, because an E instruction occupies E for exactly one cycle.
- MD counter:
  - At the edge where `md_start`=1, `md_cnt` loads MULT_CYCLES or DIV_CYCLES.
  - Otherwise, if non-zero, it decrements by 1.
  - `md_busy` = (`md_cnt` != 0).
- MD stall: raise when D holds any mult/div/mfhi/mflo/mthi/mtlo and (`md_busy` or `md_start`).
- `Stall` = data stall OR MD stall.

## Timing
- Reset: at the first rising edge with `Reset`=1, `md_cnt`=0 and `md_busy`=0. `Stall` and `md_start` follow combinationally from the inputs.
- Reset mid-operation aborts a running mult/div; the counter clears at that edge.
- MD latency: if `md_start`=1 in cycle t, `md_busy`=1 in cycles t+1..t+N and 0 in cycle t+N+1 (N = 5 or 10).
  - A dependent mfhi in D stalls in cycles t..t+N.
  - It enters E in cycle t+N+1.
- `md_start` is never asserted while `md_cnt` != 0. This is guaranteed, because the MD stall keeps a second mult/div out of E.
- Simultaneous data and MD stall: `Stall`=1. No priority is needed.
- `md_cnt` width is 4 bits, so MULT_CYCLES and DIV_CYCLES must be ≤ 15.

## Test plan
- Load-use: IMcode_E = lw $8,0($0), IMcode_D = addu $9,$8,$8 → `Stall`=1. Next cycle, with lw in M, `Stall`=0.
- Branch after ALU: E = addu $3,$1,$2, D = beq $3,$0 → `Stall`=1. With the addu in M, `Stall`=0. Repeat with a destination of $0 → `Stall`=0 throughout.
- sw store-data: E = lw $5, D = sw $5,0($6) → `Stall`=0 (rt Tuse 2 ≥ Tnew 2). E = lw $6, D = sw $5,0($6) → `Stall`=1.
- mult then mflo: E = mult $1,$2 with D = mflo $4 → `md_start`=1 for one cycle, `md_cnt` reads 5,4,3,2,1,0, and `Stall`=1 for 6 cycles before mflo advances.
- div timing: E = div, D = addu $7,$1,$2 → `Stall`=0 and `md_busy`=1 for 10 cycles. A div followed by a second div in D → the second div stalls 11 cycles.
- Reset with `md_cnt`=7: `Reset`=1 for one edge → `md_cnt`=0, `md_busy`=0, and an mfhi in D no longer stalls.
